// File: rtl/imem_loader.sv
// imem_loader: program-image loader.
// Takes the image as a byte stream (valid/ready), packs bytes big-endian into 32-bit words,
// writes them to memory from mem_start upward, reads every word back, and releases the
// processor reset only when the readback checksum matches the write checksum.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid, in_byte, in_last     byte stream from the image source
//   in_ready                       byte accepted this cycle (state-only, low during reset)
//   mem_addr, mem_din, mem_dout    memory byte address, write data, read data
//   mem_access_sz, mem_rd_wr       access size (always word), 1 = read / 0 = write
//   mem_en                         memory enable
//   word_count                     words written so far
//   done, pass, overflow           completion status
//   cpu_reset                      1 = hold the processor in reset
module imem_loader #(
    parameter logic [31:0] mem_start = 32'h0000_0000,
    parameter int unsigned max_words = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_access_sz,
    output logic        mem_rd_wr,
    output logic        mem_en,
    input  logic [31:0] mem_dout,
    output logic [15:0] word_count,
    output logic        done,
    output logic        pass,
    output logic        overflow,
    output logic        cpu_reset
);
    localparam logic [1:0]  sz_word     = 2'b11;
    localparam logic [15:0] max_words_w = 16'(max_words);

    typedef enum logic [2:0] {StFill, StWrite, StRdAddr, StRdData, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        last_q, last_d;
    logic [15:0] word_count_q, word_count_d;
    logic [15:0] rd_idx_q, rd_idx_d;
    logic [31:0] wsum_q, wsum_d;
    logic [31:0] rsum_q, rsum_d;
    logic        overflow_q, overflow_d;

    logic [31:0] shifted;
    logic        full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFill;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            rd_idx_q     <= '0;
            wsum_q       <= '0;
            rsum_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            rd_idx_q     <= rd_idx_d;
            wsum_q       <= wsum_d;
            rsum_q       <= rsum_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        rd_idx_d     = rd_idx_q;
        wsum_d       = wsum_q;
        rsum_d       = rsum_q;
        overflow_d   = overflow_q;

        in_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_rd_wr = 1'b1;
        mem_addr  = mem_start + {14'b0, word_count_q, 2'b00};
        mem_din   = '0;
        done      = 1'b0;

        shifted = {word_q[23:0], in_byte};
        full    = (word_count_q == max_words_w);

        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (full) begin
                        // Capacity reached: swallow the rest of the image.
                        overflow_d = 1'b1;
                        if (in_last) state_d = StRdAddr;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (in_last) begin
                            // Left-justify a partial word so the unfilled low bytes are zero.
                            word_d  = shifted << {(2'd3 - byte_cnt_q), 3'b000};
                            last_d  = 1'b1;
                            state_d = StWrite;
                        end else begin
                            word_d = shifted;
                            if (byte_cnt_q == 2'd3) state_d = StWrite;
                        end
                    end
                end
            end
            StWrite: begin
                mem_en       = 1'b1;
                mem_rd_wr    = 1'b0;
                mem_din      = word_q;
                wsum_d       = wsum_q + word_q;
                word_count_d = word_count_q + 16'd1;
                byte_cnt_d   = '0;
                word_d       = '0;
                state_d      = last_q ? StRdAddr : StFill;
            end
            StRdAddr: begin
                mem_en   = 1'b1;
                mem_addr = mem_start + {14'b0, rd_idx_q, 2'b00};
                state_d  = StRdData;
            end
            StRdData: begin
                rsum_d   = rsum_q + mem_dout;
                rd_idx_d = rd_idx_q + 16'd1;
                state_d  = (rd_idx_q + 16'd1 == word_count_q) ? StDone : StRdAddr;
            end
            StDone: begin
                done = 1'b1;
            end
            default: state_d = StFill;
        endcase

        // Registers already sit at reset values; only the ready strobe needs masking.
        if (reset) in_ready = 1'b0;
    end

    assign mem_access_sz = sz_word;
    assign word_count    = word_count_q;
    assign overflow      = overflow_q;
    assign pass          = done & (rsum_q == wsum_q) & ~overflow_q;
    assign cpu_reset     = ~pass;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-image loader for the MIPS benchmark system. Accepts the program as a byte stream over a valid/ready handshake, packs it big-endian into words, and writes them into the instruction/data `memory` block starting at `mem_start`. It then reads every word back and checksums it, and holds the processor in reset until the image verifies. It sits between the image source and the memory write port, replacing bench-side preloading, and drives the `reset` that the `mips` core sees.

## Interface
- `mem_start`, default `mem_start` from params.sv: byte address of word 0.
- `max_words`, default 1024: image capacity in words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a byte is offered on `in_byte`.
- `in_byte`  in  8  image byte, sent in address order.
- `in_last`  in  1  qualifies the final byte of the image; is only meaningful when `in_valid` is high.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  32  memory byte address.
- `mem_din`  out  32  memory write data.
- `mem_access_sz`  out  2  constant `sz_word`.
- `mem_rd_wr`  out  1  1 = read, 0 = write.
- `mem_en`  out  1  memory enable.
- `mem_dout`  in  32  memory read data.
- `word_count`  out  16  number of words written.
- `done`  out  1  load and verify are finished.
- `pass`  out  1  readback checksum matches and there was no overflow.
- `overflow`  out  1  the image exceeded `max_words`.
- `cpu_reset`  out  1  reset to the processor; 1 = hold the core in reset.

## Operation
- **States:** FILL, WRITE, RD_ADDR, RD_DATA, DONE. Reset enters FILL.
- **FILL:**
  - `in_ready` = 1.
  - A handshake (`in_valid` & `in_ready`) shifts `in_byte` into the word register MSB-first. `byte_cnt` counts 0..3.
  - On the 4th byte, or on a byte with `in_last`, go to WRITE.
  - When `in_last` arrives on a partial word, the unfilled low bytes are zero.
- **WRITE (1 cycle):**
  - `in_ready` = 0, `mem_en` = 1, `mem_rd_wr` = 0.
  - `mem_addr` = `mem_start` + 4·`word_count`; `mem_din` = the packed word.
  - Add `mem_din` to `wsum` (32-bit, wrap-around). Increment `word_count`. Clear `byte_cnt`.
  - Next state is RD_ADDR if the word held the last byte, otherwise FILL.
- **Overflow:**
  - When `word_count` == `max_words`, FILL keeps accepting bytes but discards them. There is no WRITE and no sum update, and `overflow` is set.
  - `in_last` then goes directly to RD_ADDR.
- **RD_ADDR:**
  - `mem_en` = 1, `mem_rd_wr` = 1, `mem_addr` = `mem_start` + 4·`rd_idx`.
  - Go to RD_DATA.
- **RD_DATA:**
  - Add `mem_dout` to `rsum`. Increment `rd_idx`.
  - If `rd_idx` + 1 == `word_count`, go to DONE; otherwise go to RD_ADDR.
- **DONE (terminal until reset):**
  - `done` = 1, `pass` = (`rsum` == `wsum`) & ~`overflow`.
  - `cpu_reset` = ~`pass`.
  - `in_ready` = 0 and `mem_en` = 0.

## Timing
- **Reset values:**
  - `in_ready` = 0, `mem_en` = 0, `mem_rd_wr` = 1, `mem_addr` = `mem_start`, `mem_din` = 0, `mem_access_sz` = `sz_word`.
  - `word_count` = 0, `done` = 0, `pass` = 0, `overflow` = 0, `cpu_reset` = 1.
  - Internal sums and indices are 0.
- **`in_ready` is a function of state only.** It never depends on `in_valid`.
- **Byte throughput:** 1 byte per cycle in FILL. Each word costs 4 FILL cycles plus 1 WRITE cycle.
- **Memory read latency:** `mem_dout` is valid in the cycle after RD_ADDR, i.e. it is sampled during RD_DATA.
- **Verify duration:** 2 cycles per word.
- **Latency to completion:** `done` and `cpu_reset` change on the edge that enters DONE. For an N-byte image with no stall, `done` rises 5·ceil(N/4) + 2·ceil(N/4) cycles after the first accepted byte, within ±1 cycle.
- **Source stalls:** `in_valid` low in FILL holds all state.
- **Reset mid-operation:** asynchronous return to FILL with reset values. `cpu_reset` goes to 1 immediately. Memory contents are not restored.
- **`in_last` on the 4th byte:** produces exactly one WRITE, then verification.

## Test plan
- **Aligned image:** bytes 8C A0 00 04 00 00 00 01, `in_last` on the last byte.
  - Writes 8CA00004 @ `mem_start` and 00000001 @ `mem_start`+4.
  - Then `word_count` = 2, `done` = 1, `pass` = 1, `cpu_reset` = 0.
- **Partial final word:** bytes 12 34 56, `in_last` on the last byte.
  - Single write of 12345600 @ `mem_start`; `pass` = 1.
- **Stalls:** `in_valid` toggled every other cycle on the aligned image.
  - Same writes and result as the aligned case; no byte lost or duplicated.
- **Overflow:** `max_words` = 2, 12 bytes.
  - Only 2 writes; `overflow` = 1, `pass` = 0, `cpu_reset` stays 1, `done` = 1.
- **Corrupted readback:** the memory model flips bit 0 of word 1 on read.
  - `done` = 1, `pass` = 0, `cpu_reset` = 1.
- **Reset mid-load:** assert `reset` after the 6th byte.
  - All outputs return to reset values within the same cycle.
  - Reload the aligned image: it completes with `pass` = 1.
